// File: rtl/seven_segment_capture_if.sv
// -----------------------------------------------------------------------------
// seven_segment_capture_if
//   Groups the display-bus inputs and the frame/status outputs of the
//   seven_segment_capture monitor.
//   Signals:
//     seg_i         segments a..g = bit6..bit0, active low
//     an_i          digit strobes, active low, bit0 = digit 0
//     frame_ack_i   consumer accepts the presented frame
//     digits_o      presented frame, digit k at [4k+3:4k]
//     frame_valid_o digits_o holds a complete, unacked frame
//     bad_seg_o     sticky: undecodable pattern captured
//     collision_o   sticky: more than one anode low for a settled period
//     overrun_o     sticky: frame completed while the previous was unacked
//   Modports:
//     master  drives the display bus and the ack (display side / consumer)
//     slave   the capture monitor
// -----------------------------------------------------------------------------
interface seven_segment_capture_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6:0]              seg_i;
  logic [NUM_DIGITS-1:0]   an_i;
  logic                    frame_ack_i;
  logic [4*NUM_DIGITS-1:0] digits_o;
  logic                    frame_valid_o;
  logic                    bad_seg_o;
  logic                    collision_o;
  logic                    overrun_o;

  modport master (
    output seg_i, an_i, frame_ack_i,
    input  digits_o, frame_valid_o, bad_seg_o, collision_o, overrun_o
  );

  modport slave (
    input  seg_i, an_i, frame_ack_i,
    output digits_o, frame_valid_o, bad_seg_o, collision_o, overrun_o
  );
endinterface

// File: rtl/seven_segment_capture.sv
// -----------------------------------------------------------------------------
// seven_segment_capture
//   Receive-side monitor for a multiplexed, active-low 7-segment display bus.
//   Each settled segment pattern under a single low anode is decoded back to a
//   BCD nibble and stored for that digit. Once every digit has been seen the
//   frame is presented on a valid/ack handshake.
//   Ports:
//     clk   system clock, rising edge
//     rst   asynchronous, active-high reset
//     bus   seven_segment_capture_if.slave (display bus in, frame/flags out)
//   Parameters:
//     NUM_DIGITS     number of multiplexed digits (anode width)
//     SETTLE_CYCLES  consecutive identical samples required before capture
// -----------------------------------------------------------------------------
module seven_segment_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  seven_segment_capture_if.slave   bus
);

  localparam int SW = NUM_DIGITS + 7;
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0]         SETTLE_MAX = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0]         CNT_ONE    = CW'(1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE     = NUM_DIGITS'(1);

  typedef enum logic {COLLECT, PRESENT} state_t;

  function automatic logic [3:0] decode(input logic [6:0] seg);
    case (seg)
      7'b0000001: decode = 4'h0;
      7'b1001111: decode = 4'h1;
      7'b0010010: decode = 4'h2;
      7'b0000110: decode = 4'h3;
      7'b1001100: decode = 4'h4;
      7'b0100100: decode = 4'h5;
      7'b0100000: decode = 4'h6;
      7'b0001111: decode = 4'h7;
      7'b0000000: decode = 4'h8;
      7'b0001100: decode = 4'h9;
      7'b1111111: decode = 4'hF;
      default:    decode = 4'hE;
    endcase
  endfunction

  // Sampling / settle counting
  logic [SW-1:0]           sample_reg;
  logic [CW-1:0]           count_reg;
  logic [SW-1:0]           new_sample;
  logic                    same;
  logic                    capture;
  logic [NUM_DIGITS-1:0]   an_low;
  logic                    multi_low;
  logic                    single_low;
  logic [3:0]              nibble;
  logic [NUM_DIGITS-1:0]   cap_mask;

  // Frame assembly
  logic [3:0]              working_reg [NUM_DIGITS];
  logic [4*NUM_DIGITS-1:0] working_flat;
  logic [NUM_DIGITS-1:0]   seen_reg;
  logic [4*NUM_DIGITS-1:0] digits_reg;
  logic                    valid_reg;
  logic                    bad_seg_reg;
  logic                    collision_reg;
  logic                    overrun_reg;
  state_t                  state_reg;

  assign new_sample = {bus.an_i, bus.seg_i};
  assign same       = (new_sample == sample_reg);

  // The count reaches SETTLE_MAX exactly once per stable period (it saturates
  // there), so firing on that transition gives one capture per hold and
  // re-arms only after the sample changes.
  assign capture    = same && (count_reg == SETTLE_MAX - CNT_ONE);

  // The registered sample equals the live inputs whenever capture fires.
  assign an_low     = ~sample_reg[SW-1:7];
  assign multi_low  = |(an_low & (an_low - AN_ONE));
  assign single_low = (an_low != '0) && !multi_low;
  assign nibble     = decode(sample_reg[6:0]);
  assign cap_mask   = (capture && single_low) ? an_low : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_reg <= '1;
      count_reg  <= '0;
    end else begin
      sample_reg <= new_sample;
      if (!same)
        count_reg <= '0;
      else if (count_reg != SETTLE_MAX)
        count_reg <= count_reg + CNT_ONE;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_work
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          working_reg[gi] <= 4'hF;
        else if (cap_mask[gi])
          working_reg[gi] <= nibble;
      end
      assign working_flat[4*gi +: 4] = working_reg[gi];
    end
  endgenerate

  // Frame FSM with status flags. A capture landing on the same edge that
  // empties the seen mask is kept, so it starts the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= COLLECT;
      seen_reg      <= '0;
      digits_reg    <= '1;
      valid_reg     <= 1'b0;
      bad_seg_reg   <= 1'b0;
      collision_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      if (cap_mask != '0 && nibble == 4'hE)
        bad_seg_reg <= 1'b1;
      if (capture && multi_low)
        collision_reg <= 1'b1;

      seen_reg <= seen_reg | cap_mask;

      case (state_reg)
        COLLECT: begin
          if (&seen_reg) begin
            digits_reg <= working_flat;
            seen_reg   <= cap_mask;
            valid_reg  <= 1'b1;
            state_reg  <= PRESENT;
          end
        end
        PRESENT: begin
          if (bus.frame_ack_i) begin
            // A complete frame pending here transfers from COLLECT next edge.
            valid_reg <= 1'b0;
            state_reg <= COLLECT;
          end else if (&seen_reg) begin
            // Consumer has not taken the old frame: drop the new one.
            overrun_reg <= 1'b1;
            seen_reg    <= cap_mask;
          end
        end
        default: state_reg <= COLLECT;
      endcase
    end
  end

  assign bus.digits_o      = digits_reg;
  assign bus.frame_valid_o = valid_reg;
  assign bus.bad_seg_o     = bad_seg_reg;
  assign bus.collision_o   = collision_reg;
  assign bus.overrun_o     = overrun_reg;

endmodule
